// File: rtl/ineq_pkg.sv
// Shared types and constants for the inequality-decoder sweep/capture stage:
// FSM encoding, default widths and the expected-table slicing helper.
package ineq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_OUT_W    = 3;
  localparam int MAX_OUT_W    = 8;
  localparam int MAX_TBL_BITS = 2048;

  // Returns entry idx of a packed table whose entries are out_w bits wide.
  function automatic logic [MAX_OUT_W-1:0] exp_entry(
    input logic [MAX_TBL_BITS-1:0] tbl,
    input int unsigned             idx,
    input int unsigned             out_w
  );
    logic [MAX_TBL_BITS-1:0] shifted;
    logic [MAX_OUT_W-1:0]    mask;
    shifted = tbl >> (idx * out_w);
    mask    = {MAX_OUT_W{1'b1}} >> (MAX_OUT_W - out_w);
    return shifted[MAX_OUT_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/ineq_table_rf.sv
// Truth-table register file: 2**DEPTH_W x DATA_W, async clear, one write port
// and a registered read port (a same-cycle read of the written address sees the old value).
module ineq_table_rf #(
  parameter int DEPTH_W = 4,
  parameter int DATA_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [DEPTH_W-1:0] waddr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [DEPTH_W-1:0] raddr,
  output logic [DATA_W-1:0]  rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**DEPTH_W; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ineq_sweep_capture.sv
// Sweeps NUM through every code, waits SETTLE cycles per code and captures the
// decoder OUT into a readable truth table. Optional expected-table compare: INEQ_CHECK_EN.
module ineq_sweep_capture
  import ineq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int SETTLE = 2,
  parameter logic [(2**WIDTH)*OUT_W-1:0] EXP_TABLE = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [OUT_W-1:0] OUT,
  output logic [WIDTH-1:0] NUM,
  output logic             BUSY,
  output logic             DONE,
  output logic             CAPT_VALID,
  input  logic [WIDTH-1:0] RD_ADDR,
  output logic [OUT_W-1:0] RD_DATA,
  output logic             MISMATCH,
  output logic [WIDTH-1:0] FAIL_IDX
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE - 1);
  localparam logic [WIDTH-1:0] LAST_IDX  = {WIDTH{1'b1}};

  if (SETTLE < 1) begin : g_bad_settle
    $error("ineq_sweep_capture: SETTLE must be at least 1");
  end
  if ($bits(EXP_TABLE) > MAX_TBL_BITS || OUT_W > MAX_OUT_W) begin : g_bad_table
    $error("ineq_sweep_capture: table too large for exp_entry helper");
  end

  state_t           state;
  logic [WIDTH-1:0] idx;
  logic [CNT_W-1:0] cnt;

  assign NUM = idx;

  // In CAPT the entry is written on the closing edge; CAPT_VALID is registered
  // on entry to CAPT so it is high exactly during that cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      CAPT_VALID <= 1'b0;
    end else begin
      DONE       <= 1'b0;
      CAPT_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            idx   <= '0;
            cnt   <= SETTLE_M1;
            BUSY  <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            CAPT_VALID <= 1'b1;
            state      <= CAPT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CAPT: begin
          if (idx == LAST_IDX) begin
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= FIN;
          end else begin
            idx   <= idx + 1'b1;
            cnt   <= SETTLE_M1;
            state <= WAIT;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  ineq_table_rf #(
    .DEPTH_W(WIDTH),
    .DATA_W (OUT_W)
  ) u_table (
    .clk  (CLK),
    .rst_n(RST_N),
    .we   (state == CAPT),
    .waddr(idx),
    .wdata(OUT),
    .raddr(RD_ADDR),
    .rdata(RD_DATA)
  );

`ifdef INEQ_CHECK_EN
  logic [OUT_W-1:0] exp_val;
  assign exp_val = OUT_W'(exp_entry(MAX_TBL_BITS'(EXP_TABLE), 32'(idx), OUT_W));

  // Only the first mismatching index of a sweep is kept.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      MISMATCH <= 1'b0;
      FAIL_IDX <= '0;
    end else if (state == IDLE && START) begin
      MISMATCH <= 1'b0;
      FAIL_IDX <= '0;
    end else if (state == CAPT && !MISMATCH && OUT != exp_val) begin
      MISMATCH <= 1'b1;
      FAIL_IDX <= idx;
    end
  end
`else
  assign MISMATCH = 1'b0;
  assign FAIL_IDX = '0;
`endif

endmodule

// File: tb/tb_ineq_sweep_capture.sv
// Directed bench for ineq_sweep_capture: table-driven reads plus hand sequences
// for sweep timing, ignored/held START, delayed decoder model and mid-sweep reset.
module tb_ineq_sweep_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start_s1 = 1'b0;
  logic       model_delay = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [3:0] rd_addr_s1 = '0;

  logic [2:0] out, out_s1;
  logic [3:0] num, num_s1;
  logic       busy, done, capt_valid, mismatch;
  logic       busy_s1, done_s1, capt_valid_s1, mismatch_s1;
  logic [2:0] rd_data, rd_data_s1;
  logic [3:0] fail_idx, fail_idx_s1;

  int checks = 0;
  int errors = 0;

  int done_edge, busy_cnt, capt_cnt, done_cnt, rise_edge, s1_done_edge;
  logic mm_at_done, mm_after_accept;

`ifdef INEQ_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  function automatic logic [47:0] make_exp_table();
    logic [47:0] t;
    for (int i = 0; i < 16; i++) begin
      t[i*3 +: 3] = (i == 6) ? 3'b101 : 3'(i);
    end
    return t;
  endfunction

  localparam logic [47:0] EXP_TBL = make_exp_table();

  always #5 clk = ~clk;

  // Decoder models: direct NUM[2:0], or NUM[2:0] through a two-stage pipe.
  logic [2:0] d1 = '0, d2 = '0, e1 = '0, e2 = '0;
  always @(posedge clk) begin
    d1 <= num[2:0];
    d2 <= d1;
    e1 <= num_s1[2:0];
    e2 <= e1;
  end
  assign out    = model_delay ? d2 : num[2:0];
  assign out_s1 = e2;

  ineq_sweep_capture #(
    .WIDTH(4), .OUT_W(3), .SETTLE(2), .EXP_TABLE(EXP_TBL)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .OUT(out), .NUM(num),
    .BUSY(busy), .DONE(done), .CAPT_VALID(capt_valid),
    .RD_ADDR(rd_addr), .RD_DATA(rd_data),
    .MISMATCH(mismatch), .FAIL_IDX(fail_idx)
  );

  ineq_sweep_capture #(
    .WIDTH(4), .OUT_W(3), .SETTLE(1), .EXP_TABLE(EXP_TBL)
  ) dut_s1 (
    .CLK(clk), .RST_N(rst_n), .START(start_s1), .OUT(out_s1), .NUM(num_s1),
    .BUSY(busy_s1), .DONE(done_s1), .CAPT_VALID(capt_valid_s1),
    .RD_ADDR(rd_addr_s1), .RD_DATA(rd_data_s1),
    .MISMATCH(mismatch_s1), .FAIL_IDX(fail_idx_s1)
  );

  typedef struct {
    logic [3:0] addr;
    logic [2:0] exp;
  } read_vec_t;

  read_vec_t read_vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] addr);
    @(negedge clk);
    rd_addr = addr;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Edge 0 is the START-accept edge; results are sampled on the following negedge.
  task automatic runSweep(input int restart_at, input bit hold, input bit with_s1, input int n_cycles);
    done_edge = -1; rise_edge = -1; s1_done_edge = -1; done_cnt = 0;
    mm_at_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    start_s1 = with_s1;
    @(posedge clk);
    @(negedge clk);
    busy_cnt = int'(busy);
    capt_cnt = int'(capt_valid);
    mm_after_accept = mismatch;
    start_s1 = 1'b0;
    for (int e = 1; e <= n_cycles; e++) begin
      start = hold || (e == restart_at);
      @(posedge clk);
      @(negedge clk);
      busy_cnt += int'(busy);
      capt_cnt += int'(capt_valid);
      if (done) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge  = e;
          mm_at_done = mismatch;
        end
      end
      if (done_edge >= 0 && e > done_edge && busy && rise_edge < 0) rise_edge = e;
      if (done_s1 && s1_done_edge < 0) s1_done_edge = e;
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    read_vecs[0] = '{4'd6,  3'b110};
    read_vecs[1] = '{4'd13, 3'b101};
    read_vecs[2] = '{4'd0,  3'b000};
    read_vecs[3] = '{4'd15, 3'b111};
    read_vecs[4] = '{4'd7,  3'b111};
    read_vecs[5] = '{4'd8,  3'b000};

    // Reset held with START high.
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_num",        32'(num),        32'd0);
    checkOutput("rst_busy",       32'(busy),       32'd0);
    checkOutput("rst_done",       32'(done),       32'd0);
    checkOutput("rst_capt_valid", 32'(capt_valid), 32'd0);
    checkOutput("rst_rd_data",    32'(rd_data),    32'd0);
    checkOutput("rst_mismatch",   32'(mismatch),   32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("idle_busy",       32'(busy),       32'd0);
    checkOutput("idle_capt_valid", 32'(capt_valid), 32'd0);

    // Direct model sweep, with an extra START at cycle 10 that must be ignored.
    $display("[TB] sweep SETTLE=2, direct model");
    model_delay = 1'b0;
    runSweep(10, 1'b0, 1'b0, 60);
    checkOutput("sweep_done_edge", 32'(done_edge), 32'd48);
    checkOutput("sweep_done_cnt",  32'(done_cnt),  32'd1);
    checkOutput("sweep_busy_cnt",  32'(busy_cnt),  32'd48);
    checkOutput("sweep_capt_cnt",  32'(capt_cnt),  32'd16);
    checkOutput("sweep_num_end",   32'(num),       32'd15);
    checkOutput("sweep_mm_done",   32'(mm_at_done), 32'(CHECK_EN));
    checkOutput("sweep_fail_idx",  32'(fail_idx),  CHECK_EN ? 32'd6 : 32'd0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(read_vecs[i].addr);
      checkOutput($sformatf("read_addr%0d", read_vecs[i].addr), 32'(rd_data), 32'(read_vecs[i].exp));
    end

    // Delayed decoder: SETTLE=2 captures fresh data, SETTLE=1 captures stale data.
    $display("[TB] sweep with two-cycle decoder delay");
    model_delay = 1'b1;
    runSweep(-1, 1'b0, 1'b1, 60);
    checkOutput("restart_mm_clear", 32'(mm_after_accept), 32'd0);
    checkOutput("delay_done_edge",  32'(done_edge),       32'd48);
    checkOutput("s1_done_edge",     32'(s1_done_edge),    32'd32);
    rd_addr_s1 = 4'd6;
    applyStimulus(4'd6);
    checkOutput("delay_s2_entry6", 32'(rd_data),    32'd6);
    checkOutput("delay_s1_entry6", 32'(rd_data_s1), 32'd5);

    // START held high: second accept one IDLE cycle after FIN.
    $display("[TB] START held high");
    model_delay = 1'b0;
    runSweep(-1, 1'b1, 1'b0, 55);
    checkOutput("hold_done_edge", 32'(done_edge), 32'd48);
    checkOutput("hold_rise_edge", 32'(rise_edge), 32'd50);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a sweep.
    $display("[TB] mid-sweep reset");
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    checkOutput("pre_abort_num", 32'(num), 32'd6);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_num",  32'(num),  32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int e = 0; e < 60; e++) begin
      @(posedge clk);
      @(negedge clk);
      done_cnt += int'(done);
    end
    checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
    applyStimulus(4'd0);
    checkOutput("abort_entry0", 32'(rd_data), 32'd0);
    applyStimulus(4'd6);
    checkOutput("abort_entry6", 32'(rd_data), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ineq_sweep_capture.md
Name: ineq_sweep_capture

Overview:
Sequential stimulus/capture stage that sits directly around the 4-bit inequality decoder. It drives the decoder's NUM input through every code 0..15 and waits a programmable settle time per code. It samples the decoder's 3-bit OUT into an internal truth-table register file, and exposes the table through a registered read port with a START/BUSY/DONE handshake.

Parameters:
WIDTH, 4, width of NUM; table depth is 2**WIDTH
OUT_W, 3, width of decoder OUT and of each table entry
SETTLE, 2, cycles NUM is held before sampling; must be >=1, elaboration error if 0
EXP_TABLE, 0 (all entries), expected table, entry i at bits [i*OUT_W +: OUT_W]; used only with INEQ_CHECK_EN

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  sweep request, sampled only in IDLE
OUT  in  OUT_W  result from the inequality decoder
NUM  out  WIDTH  code driven to the decoder; registered
BUSY  out  1  high from the START-accept edge until FIN
DONE  out  1  one-cycle pulse when the table is complete
CAPT_VALID  out  1  one-cycle pulse per captured entry
RD_ADDR  in  WIDTH  table read address
RD_DATA  out  OUT_W  table[RD_ADDR], 1-cycle registered latency
MISMATCH  out  1  sticky compare failure (INEQ_CHECK_EN only)
FAIL_IDX  out  WIDTH  index of first mismatch (INEQ_CHECK_EN only)

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE, NUM=0, idx=0, settle count=0, BUSY=0, DONE=0, CAPT_VALID=0, RD_DATA=0, all table entries=0, MISMATCH=0, FAIL_IDX=0. Reset asserted mid-sweep aborts immediately: no DONE, and the table is cleared.
- NUM is the idx register itself; no combinational path from START to NUM.
- FSM states: IDLE, WAIT, CAPT, FIN.
- IDLE: if START=1, then idx<=0, cnt<=SETTLE-1, BUSY<=1, go to WAIT. Otherwise hold.
- WAIT: if cnt==0, go to CAPT; otherwise cnt<=cnt-1.
- CAPT: table[idx]<=OUT and CAPT_VALID=1 for this cycle.
  - If idx==2**WIDTH-1, go to FIN; idx is not incremented, so NUM holds 15.
  - Otherwise idx<=idx+1, cnt<=SETTLE-1, go to WAIT.
- FIN: DONE=1 and BUSY=0 for exactly one cycle, then go to IDLE.
- Timing: each entry costs SETTLE+1 cycles. With START sampled at edge 0, the last capture happens at edge 16*(SETTLE+1) and DONE is high in the following cycle. For SETTLE=2 that is edge 48.
- START while BUSY, or during the FIN cycle, is ignored. START held high continuously gives back-to-back sweeps, with one IDLE cycle between FIN and the next accept.
- Reads are allowed at any time. A read of the address being written in the same cycle returns the old value. Partial contents are visible mid-sweep.
- NUM keeps its last value after FIN until the next START.

Optional Feature:
Macro: INEQ_CHECK_EN.
- Defined: on each CAPT, OUT is compared with the EXP_TABLE entry for idx.
  - On the first inequality, MISMATCH<=1 and FAIL_IDX<=idx.
  - MISMATCH is sticky until the next START accept or reset, both of which clear MISMATCH and FAIL_IDX.
- Undefined: no compare logic; MISMATCH and FAIL_IDX are tied to 0, and the ports remain present.

Decomposition:
- Shared package ineq_pkg holds:
  - FSM state encoding constants (IDLE=0, WAIT=1, CAPT=2, FIN=3, 2 bits)
  - default WIDTH and OUT_W constants
  - the EXP_TABLE entry-slicing helper
- One natural sub-module: ineq_table_rf, the 2**WIDTH x OUT_W register file with async clear, one write port and a registered read port.
- The FSM and counters stay in ineq_sweep_capture.

Test Plan:
1. Hold RST_N=0 with START=1 -> NUM=0, BUSY=0, DONE=0, CAPT_VALID=0, RD_DATA=0, MISMATCH=0. After release with no START, the block stays in IDLE.
2. SETTLE=2, bench model OUT=NUM[2:0], 1-cycle START pulse -> BUSY high 48 cycles, 16 CAPT_VALID pulses, DONE high the cycle after edge 48, NUM=15. Then reads give RD_ADDR=6 -> 3'b110 and RD_ADDR=13 -> 3'b101, one cycle after each address is applied.
3. Bench model OUT = NUM[2:0] delayed by 2 cycles:
   - SETTLE=2 -> entry 6 = 3'b110 (correct).
   - SETTLE=1 -> entry 6 = 3'b101 (stale value from previous code).
4. START pulsed again at cycle 10 -> ignored; DONE still at edge 48. START held high -> second sweep accepted on the edge after the FIN cycle.
5. RST_N pulsed low at cycle 20 mid-sweep -> NUM=0 and BUSY=0 immediately, no DONE, RD_ADDR=0 reads 0.
6. INEQ_CHECK_EN with EXP_TABLE entry 6 = 3'b101 and model OUT=NUM[2:0] -> MISMATCH=1 after capture of idx 6 and FAIL_IDX=6, both held through DONE; the next START clears both.
